// File: rtl/booth_mult_ctrl_if.sv
// Start/done handshake bundle between the issuing control logic and the
// Booth multiplier.
//   start        : request pulse from issuer
//   multiplicand : signed operand M
//   multiplier   : signed operand Q
//   busy         : multiplier is in RUN or DONE
//   done         : one-cycle pulse, product valid
//   product      : 2W-bit signed result, held until the next result
interface booth_mult_ctrl_if #(
    parameter int unsigned W = 8
);
    logic             start;
    logic [W-1:0]     multiplicand;
    logic [W-1:0]     multiplier;
    logic             busy;
    logic             done;
    logic [2*W-1:0]   product;

    modport master (
        output start, multiplicand, multiplier,
        input  busy, done, product
    );

    modport slave (
        input  start, multiplicand, multiplier,
        output busy, done, product
    );
endinterface

// File: rtl/booth_mult_ctrl.sv
// Sequential radix-2 Booth signed multiplier controller.
// W iterations of add/subtract/arithmetic-shift produce the exact 2W-bit
// two's-complement product.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : slave side of booth_mult_ctrl_if (start/operands in,
//           busy/done/product out, all outputs registered)
module booth_mult_ctrl #(
    parameter int unsigned W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    booth_mult_ctrl_if.slave  bus
);

    localparam int unsigned AW    = W + 1;
    localparam int unsigned PW    = 2 * W;
    localparam int unsigned CNT_W = $clog2(W + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [AW-1:0]    a_q, a_d;
    logic [AW-1:0]    m_q, m_d;
    logic [W-1:0]     q_q, q_d;
    logic             qm1_q, qm1_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [PW-1:0]    product_q, product_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic [AW-1:0]    a_sum;
    logic             accept;

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            a_q       <= '0;
            m_q       <= '0;
            q_q       <= '0;
            qm1_q     <= 1'b0;
            cnt_q     <= '0;
            product_q <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            a_q       <= a_d;
            m_q       <= m_d;
            q_q       <= q_d;
            qm1_q     <= qm1_d;
            cnt_q     <= cnt_d;
            product_q <= product_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    // Next-state, Booth iteration and registered-output logic
    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        m_d       = m_q;
        q_d       = q_q;
        qm1_d     = qm1_q;
        cnt_d     = cnt_q;
        product_d = product_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        a_sum     = a_q;
        accept    = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    accept = 1'b1;
                end
            end

            RUN: begin
                case ({q_q[0], qm1_q})
                    2'b01:   a_sum = a_q + m_q;
                    2'b10:   a_sum = a_q - m_q;
                    default: a_sum = a_q;
                endcase
                // Arithmetic right shift of {A', Q, q_m1}
                a_d   = {a_sum[AW-1], a_sum[AW-1:1]};
                q_d   = {a_sum[0], q_q[W-1:1]};
                qm1_d = q_q[0];
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d   = DONE;
                    done_d    = 1'b1;
                    product_d = {a_d[W-1:0], q_d};
                end
            end

            DONE: begin
                // The DONE edge is also the first edge a new request can be
                // taken, giving one multiply every W+1 cycles.
                if (bus.start) begin
                    accept = 1'b1;
                end else begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                end
            end

            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase

        // Operand load on an accepting edge; M gets one guard bit so that
        // subtracting -2^(W-1) cannot overflow.
        if (accept) begin
            state_d = RUN;
            busy_d  = 1'b1;
            a_d     = '0;
            q_d     = bus.multiplier;
            qm1_d   = 1'b0;
            m_d     = {bus.multiplicand[W-1], bus.multiplicand};
            cnt_d   = CNT_W'(W);
        end
    end

    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.product = product_q;

endmodule

// File: tb/tb_booth_mult_ctrl.sv
// Self-checking bench for booth_mult_ctrl (W=8): scenario tasks with a
// queue of expected products pushed at issue and popped on done.
module tb_booth_mult_ctrl;

    localparam int unsigned W  = 8;
    localparam int unsigned PW = 2 * W;

    logic clk;
    logic rst_n;

    booth_mult_ctrl_if #(.W(W)) bus ();

    booth_mult_ctrl #(.W(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    int total;
    int bad;
    logic [PW-1:0] exp_q[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [PW-1:0] model(input logic [W-1:0] m, input logic [W-1:0] q);
        logic signed [PW-1:0] sm;
        logic signed [PW-1:0] sq;
        sm = $signed(m);
        sq = $signed(q);
        return PW'(sm * sq);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drive one start pulse; returns right after the accepting edge.
    task automatic issue(input logic [W-1:0] m, input logic [W-1:0] q);
        bus.start        = 1'b1;
        bus.multiplicand = m;
        bus.multiplier   = q;
        exp_q.push_back(model(m, q));
        step();
        bus.start        = 1'b0;
        bus.multiplicand = W'($urandom);
        bus.multiplier   = W'($urandom);
    endtask

    // Bounded wait for done; n is edges after acceptance (0 on timeout).
    task automatic wait_done(output int n);
        n = 0;
        for (int i = 1; i <= 30; i++) begin
            step();
            if (bus.done === 1'b1) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic test_reset();
        logic [PW-1:0] dummy;
        int dones;
        rst_n = 1'b0;
        #2;
        total++;
        if ({bus.busy, bus.done, bus.product} !== {2'b00, PW'(0)}) begin
            bad++;
            $display("FAIL reset_init busy=%b done=%b product=%h want 0 0 0000",
                     bus.busy, bus.done, bus.product);
        end
        step();
        rst_n = 1'b1;
        step();
        issue(8'h05, 8'h07);
        step();
        step();
        #3;
        rst_n = 1'b0;
        #1;
        total++;
        if ({bus.busy, bus.done, bus.product} !== {2'b00, PW'(0)}) begin
            bad++;
            $display("FAIL reset_midrun busy=%b done=%b product=%h want 0 0 0000",
                     bus.busy, bus.done, bus.product);
        end
        dummy = exp_q.pop_front();
        step();
        rst_n = 1'b1;
        dones = 0;
        for (int i = 0; i < 15; i++) begin
            step();
            if (bus.done === 1'b1 || bus.busy === 1'b1) dones++;
        end
        total++;
        if (dones !== 0) begin
            bad++;
            $display("FAIL reset_abort_quiet done_or_busy_cycles=%0d want 0", dones);
        end
    endtask

    task automatic test_neg_one();
        int n;
        logic [PW-1:0] e;
        issue(8'hFF, 8'hFF);
        wait_done(n);
        total++;
        if (n !== 8) begin
            bad++;
            $display("FAIL neg1_latency edges=%0d want 8", n);
        end
        e = exp_q.pop_front();
        total++;
        if (bus.product !== e || bus.product !== 16'h0001) begin
            bad++;
            $display("FAIL neg1_product got=%h want=%h", bus.product, e);
        end
        step();
        total++;
        if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
            bad++;
            $display("FAIL neg1_after done=%b busy=%b want 0 0", bus.done, bus.busy);
        end
    endtask

    task automatic test_products();
        logic [W-1:0] ms[8] = '{8'h80, 8'h80, 8'h75, 8'hF2, 8'h7F, 8'h00, 8'h01, 8'h80};
        logic [W-1:0] qs[8] = '{8'h80, 8'h7F, 8'hF2, 8'h75, 8'h81, 8'h9C, 8'hFF, 8'h01};
        logic [PW-1:0] ks[4] = '{16'h4000, 16'hC080, 16'hF99A, 16'hF99A};
        int n;
        logic [PW-1:0] e;
        for (int i = 0; i < 8 + 6; i++) begin
            logic [W-1:0] m;
            logic [W-1:0] q;
            if (i < 8) begin
                m = ms[i];
                q = qs[i];
            end else begin
                m = W'($urandom);
                q = W'($urandom);
            end
            issue(m, q);
            wait_done(n);
            e = exp_q.pop_front();
            total++;
            if (n !== 8 || bus.product !== e) begin
                bad++;
                $display("FAIL product_%0d m=%h q=%h got=%h edges=%0d want=%h edges=8",
                         i, m, q, bus.product, n, e);
            end
            if (i < 4) begin
                total++;
                if (bus.product !== ks[i]) begin
                    bad++;
                    $display("FAIL product_const_%0d got=%h want=%h", i, bus.product, ks[i]);
                end
            end
            step();
        end
    endtask

    task automatic test_busy_protect();
        int dones;
        logic [PW-1:0] e;
        logic [PW-1:0] seen;
        issue(8'h03, 8'h05);
        step();
        bus.start        = 1'b1;
        bus.multiplicand = 8'h7F;
        bus.multiplier   = 8'h7F;
        step();
        bus.start = 1'b0;
        dones = 0;
        seen  = '0;
        for (int i = 0; i < 25; i++) begin
            step();
            if (bus.done === 1'b1) begin
                dones++;
                seen = bus.product;
            end
        end
        e = exp_q.pop_front();
        total++;
        if (dones !== 1) begin
            bad++;
            $display("FAIL busy_done_count got=%0d want 1", dones);
        end
        total++;
        if (seen !== e || bus.product !== 16'h000F) begin
            bad++;
            $display("FAIL busy_product got=%h want=%h", seen, e);
        end
    endtask

    task automatic test_back_to_back();
        int last;
        int dones;
        int errs;
        logic [PW-1:0] e;
        bus.start        = 1'b1;
        bus.multiplicand = 8'h02;
        bus.multiplier   = 8'hFD;
        for (int k = 0; k < 8; k++) exp_q.push_back(model(8'h02, 8'hFD));
        step();
        last  = 0;
        dones = 0;
        errs  = 0;
        for (int i = 1; i <= 40; i++) begin
            step();
            if (bus.done === 1'b1) begin
                e = exp_q.pop_front();
                if (bus.product !== e) errs++;
                if ((dones == 0 && i != 8) || (dones != 0 && i - last != 9)) errs++;
                last = i;
                dones++;
            end
        end
        bus.start = 1'b0;
        total++;
        if (dones !== 4 || errs !== 0) begin
            bad++;
            $display("FAIL b2b_stream dones=%0d errs=%0d want 4 0", dones, errs);
        end
        for (int i = 0; i < 20 && bus.busy === 1'b1; i++) begin
            step();
            if (bus.done === 1'b1) begin
                e = exp_q.pop_front();
                total++;
                if (bus.product !== e || bus.product !== 16'hFFFA) begin
                    bad++;
                    $display("FAIL b2b_tail_product got=%h want=%h", bus.product, e);
                end
            end
        end
        total++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
            bad++;
            $display("FAIL b2b_idle busy=%b done=%b want 0 0", bus.busy, bus.done);
        end
        exp_q.delete();
    endtask

    initial begin
        total            = 0;
        bad              = 0;
        bus.start        = 1'b0;
        bus.multiplicand = '0;
        bus.multiplier   = '0;
        rst_n            = 1'b0;
        test_reset();
        test_neg_one();
        test_products();
        test_busy_protect();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
